// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the raster timing generator.
//   - default 800x600@60 mode constants
//   - vga_region_e: per-axis region decode (sync, back porch, active, front porch)
//   - vga_sig_t: packed bundle of every signal carried through the output delay line
//   - helpers: counter width, region decode, idle (reset) value of the bundle
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_H_FP     = 40;
  localparam int unsigned DEF_H_SYNC   = 128;
  localparam int unsigned DEF_H_BP     = 88;
  localparam int unsigned DEF_V_ACTIVE = 600;
  localparam int unsigned DEF_V_FP     = 1;
  localparam int unsigned DEF_V_SYNC   = 4;
  localparam int unsigned DEF_V_BP     = 23;

  localparam int unsigned DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;

  // Field widths inside the delayed bundle. They are upper bounds; the top
  // module checks its actual widths against them at elaboration.
  localparam int unsigned SIG_CW = 16;
  localparam int unsigned SIG_RW = 16;
  localparam int unsigned SIG_FW = 32;

  typedef enum logic [1:0] {
    SYNC,
    BACK,
    ACTIVE,
    FRONT
  } vga_region_e;

  typedef struct packed {
    logic              hs;
    logic              vs;
    logic              blank;
    logic              line_start;
    logic              frame_start;
    logic              vis_end;
    logic [SIG_CW-1:0] col;
    logic [SIG_RW-1:0] row;
    logic [SIG_FW-1:0] frame_count;
  } vga_sig_t;

  // $clog2 with a floor of one bit, so a range of 1 still yields a legal vector.
  function automatic int unsigned width_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Regions are laid out from count 0 in the order sync, back porch, active, front porch.
  function automatic vga_region_e region_of(input int unsigned cnt,
                                            input int unsigned sync_len,
                                            input int unsigned bp_len,
                                            input int unsigned act_len);
    if (cnt < sync_len)
      return SYNC;
    if (cnt < sync_len + bp_len)
      return BACK;
    if (cnt < sync_len + bp_len + act_len)
      return ACTIVE;
    return FRONT;
  endfunction

  // Value held by every delay stage while in reset: syncs deasserted, blanked, no pulses.
  function automatic vga_sig_t idle_sig(input logic hs_pol, input logic vs_pol);
    vga_sig_t s;
    s       = '0;
    s.hs    = ~hs_pol;
    s.vs    = ~vs_pol;
    s.blank = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/vga_delay.sv
// vga_delay: DEPTH-stage shift register of vga_sig_t with synchronous reset.
//   clock  in   pixel clock
//   reset  in   synchronous, active-high; loads RST_VAL into every stage
//   d      in   raw per-cycle timing bundle
//   q      out  bundle delayed by DEPTH clocks
module vga_delay
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH   = 1,
  parameter vga_sig_t    RST_VAL = '0
) (
  input  logic     clock,
  input  logic     reset,
  input  vga_sig_t d,
  output vga_sig_t q
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("vga_delay: DEPTH must be at least 1");
  end

  vga_sig_t [DEPTH-1:0] stage;

  if (DEPTH == 1) begin : g_single
    always_ff @(posedge clock) begin
      if (reset)
        stage[0] <= RST_VAL;
      else
        stage[0] <= d;
    end
  end else begin : g_chain
    // stage[0] is the newest entry, stage[DEPTH-1] the oldest.
    always_ff @(posedge clock) begin
      if (reset)
        stage <= {DEPTH{RST_VAL}};
      else
        stage <= {stage[DEPTH-2:0], d};
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
//   clock        in   pixel clock
//   reset        in   synchronous, active-high
//   HS, VS       out  syncs, asserted at HS_POL / VS_POL
//   blank        out  1 outside the visible region
//   col, row     out  visible pixel coordinate, 0 while blanked
//   line_start   out  pulse at hcount = 0
//   frame_start  out  pulse at hcount = 0, vcount = 0
//   vis_end      out  pulse on the last visible pixel of the frame
//   frame_count  out  completed frames, wraps at 2^FRAME_W
// All outputs are computed from hcount/vcount and delayed by LATENCY stages.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned LATENCY  = 1,
  parameter int unsigned FRAME_W  = 8,
  localparam int unsigned CW      = width_of(H_ACTIVE),
  localparam int unsigned RW      = width_of(V_ACTIVE)
) (
  input  logic               clock,
  input  logic               reset,
  output logic               HS,
  output logic               VS,
  output logic               blank,
  output logic [CW-1:0]      col,
  output logic [RW-1:0]      row,
  output logic               line_start,
  output logic               frame_start,
  output logic               vis_end,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned HCW     = width_of(H_TOTAL);
  localparam int unsigned VCW     = width_of(V_TOTAL);

  localparam logic [HCW-1:0] H_LAST      = HCW'(H_TOTAL - 1);
  localparam logic [VCW-1:0] V_LAST      = VCW'(V_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT_FIRST = HCW'(H_SYNC + H_BP);
  localparam logic [VCW-1:0] V_ACT_FIRST = VCW'(V_SYNC + V_BP);
  localparam logic [HCW-1:0] H_ACT_LAST  = HCW'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [VCW-1:0] V_ACT_LAST  = VCW'(V_SYNC + V_BP + V_ACTIVE - 1);

  localparam vga_sig_t IDLE = idle_sig(HS_POL, VS_POL);

  // Elaboration-time parameter checks.
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0) begin : g_bad_h
    $error("vga_timing_gen: horizontal sync, porches and active width must be non-zero");
  end
  if (V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_v
    $error("vga_timing_gen: vertical sync, porches and active height must be non-zero");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("vga_timing_gen: LATENCY must be at least 1");
  end
  if (FRAME_W < 1 || FRAME_W > SIG_FW) begin : g_bad_frame_w
    $error("vga_timing_gen: FRAME_W out of range");
  end
  if (CW > SIG_CW || RW > SIG_RW) begin : g_bad_coord_w
    $error("vga_timing_gen: active area too large for the delayed bundle");
  end

  // ---------------------------------------------------------------------
  // Raster counters and completed-frame counter
  // ---------------------------------------------------------------------
  logic [HCW-1:0]     hcount;
  logic [VCW-1:0]     vcount;
  logic [FRAME_W-1:0] frame_cnt;
  logic               h_wrap;
  logic               v_wrap;

  always_comb begin
    h_wrap = (hcount == H_LAST);
    v_wrap = (vcount == V_LAST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hcount    <= '0;
      vcount    <= '0;
      frame_cnt <= '0;
    end else begin
      hcount <= h_wrap ? '0 : hcount + 1'b1;
      if (h_wrap)
        vcount <= v_wrap ? '0 : vcount + 1'b1;
      if (h_wrap && v_wrap)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Per-cycle raw outputs
  // ---------------------------------------------------------------------
  vga_region_e   h_region;
  vga_region_e   v_region;
  logic          visible;
  logic [CW-1:0] h_off;
  logic [RW-1:0] v_off;
  vga_sig_t      raw;

  always_comb begin
    h_region = region_of(32'(hcount), H_SYNC, H_BP, H_ACTIVE);
    v_region = region_of(32'(vcount), V_SYNC, V_BP, V_ACTIVE);
    visible  = (h_region == ACTIVE) && (v_region == ACTIVE);
    // Active width always fits in CW bits, so the truncated offset is exact.
    h_off    = CW'(hcount - H_ACT_FIRST);
    v_off    = RW'(vcount - V_ACT_FIRST);

    raw             = IDLE;
    raw.hs          = (h_region == SYNC) ? HS_POL : ~HS_POL;
    raw.vs          = (v_region == SYNC) ? VS_POL : ~VS_POL;
    raw.blank       = ~visible;
    raw.line_start  = (hcount == '0);
    raw.frame_start = (hcount == '0) && (vcount == '0);
    raw.vis_end     = (hcount == H_ACT_LAST) && (vcount == V_ACT_LAST);
    // frame_cnt already counts the frame that wrapped on the previous edge,
    // so it travels with frame_start through the delay line.
    raw.frame_count = SIG_FW'(frame_cnt);
    if (visible) begin
      raw.col = SIG_CW'(h_off);
      raw.row = SIG_RW'(v_off);
    end
  end

  // ---------------------------------------------------------------------
  // Output alignment
  // ---------------------------------------------------------------------
  vga_sig_t dly;

  vga_delay #(
    .DEPTH   (LATENCY),
    .RST_VAL (IDLE)
  ) u_delay (
    .clock (clock),
    .reset (reset),
    .d     (raw),
    .q     (dly)
  );

  always_comb begin
    HS          = dly.hs;
    VS          = dly.vs;
    blank       = dly.blank;
    line_start  = dly.line_start;
    frame_start = dly.frame_start;
    vis_end     = dly.vis_end;
    col         = CW'(dly.col);
    row         = RW'(dly.row);
    frame_count = FRAME_W'(dly.frame_count);
  end

  // Upper bundle bits are always zero for this configuration.
  logic unused_pad;
  assign unused_pad = ^{dly.col, dly.row, dly.frame_count};

endmodule
